// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - LEGv8 data-memory responder with fixed-latency valid/ready request and response channels
//
// Purpose: slave end of the core's load/store interface. It accepts one request at a time,
// waits LATENCY cycles, then commits the access to a DEPTH x WORD array and presents a
// registered response until the initiator takes it. Misaligned, out-of-range and malformed
// requests complete with resp_err = 1 and never touch the array.
//
// Ports:
//   clk        in   1     clock, all state updates on the rising edge
//   rst        in   1     synchronous active-high reset
//   req_valid  in   1     initiator presents a request
//   req_ready  out  1     responder can accept a request this cycle
//   MemRead    in   1     request is a load
//   MemWrite   in   1     request is a store
//   addr       in   WORD  byte address
//   w_data     in   WORD  store data
//   resp_valid out  1     a response is presented
//   resp_ready in   1     initiator takes the response this cycle
//   r_data     out  WORD  load data, 0 for stores and errors
//   resp_err   out  1     request was rejected
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int WORD    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] w_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] r_data,
  output logic            resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  // The wait counter counts down to 0 and the transition to RESP takes one more edge,
  // so it is preloaded with LATENCY-2 (unused when LATENCY is 1).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request captured at acceptance
  logic             rd_q, wr_q;
  logic [WORD-1:0]  addr_q, wdata_q;

  // Registered response
  logic [WORD-1:0]  r_data_q;
  logic             err_q;

  logic [WORD-1:0]  mem [DEPTH];

  logic             accept;
  logic             commit;

  // Request being committed: with LATENCY 1 the commit edge is the acceptance edge,
  // so the live inputs are used while IDLE; otherwise the captured copy is used.
  logic             cur_rd, cur_wr;
  logic [WORD-1:0]  cur_addr, cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_err;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign accept     = req_valid && req_ready;
  assign r_data     = r_data_q;
  assign resp_err   = err_q;

  always_comb begin
    if (state_q == S_IDLE) begin
      cur_rd    = MemRead;
      cur_wr    = MemWrite;
      cur_addr  = addr;
      cur_wdata = w_data;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_idx = cur_addr[IDX_W+2:3];
    cur_err = (cur_addr[2:0] != 3'b000)
           || ((cur_addr >> (IDX_W + 3)) != '0)
           || (cur_rd == cur_wr);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        addr_q  <= addr;
        wdata_q <= w_data;
      end
      if (commit) begin
        r_data_q <= (cur_rd && !cur_err) ? mem[cur_idx] : '0;
        err_q    <= cur_err;
      end
    end
  end

  // Array has no reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_wr && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule
